// File: rtl/fft_psd_avg.sv
// Per-bin power |X|^2 averaged over 2^AVG_LOG2 FFT frames; streams one averaged spectrum per period.
// Define FFT_PSD_AVG_PEAK_EN to add per-spectrum peak (max power, lowest bin) reporting.

module fft_psd_avg #(
  parameter int unsigned IN_W     = 28,
  parameter int unsigned FFT_LEN  = 256,
  parameter int unsigned AVG_LOG2 = 4
) (
  input  logic                       mclk,
  input  logic                       i_init,
  input  logic                       i_vld,
  input  logic                       i_new_fft,
  input  logic signed [IN_W-1:0]     i_I,
  input  logic signed [IN_W-1:0]     i_Q,
  output logic                       o_vld,
  output logic                       o_new_frame,
  output logic [$clog2(FFT_LEN)-1:0] o_bin,
  output logic [2*IN_W-1:0]          o_pwr,
  output logic                       o_err_strb,
  output logic                       o_peak_vld,
  output logic [$clog2(FFT_LEN)-1:0] o_peak_bin,
  output logic [2*IN_W-1:0]          o_peak_pwr
);

  localparam int unsigned STAGES = $clog2(FFT_LEN);
  localparam int unsigned P_W    = 2 * IN_W;
  localparam int unsigned ACC_W  = P_W + AVG_LOG2;
  localparam int unsigned FC_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [FC_W-1:0]   LastFrame = FC_W'((1 << AVG_LOG2) - 1);
  localparam logic [STAGES-1:0] LastBin   = STAGES'(FFT_LEN - 1);
  localparam logic [FC_W-1:0]   Frame0    = FC_W'(0);

  typedef enum logic [0:0] {StSync, StAccum} state_e;

  state_e            state_q;
  logic [STAGES-1:0] bin_q;
  logic [FC_W-1:0]   frame_q;

  // Stage 1 token: products plus control
  logic                  v1_q, first1_q, last1_q;
  logic [STAGES-1:0]     bin1_q;
  logic signed [P_W-1:0] i_ext, q_ext, ii_q, qq_q;

  // Stage 2 token: power plus RAM read data
  logic                  v2_q, first2_q, last2_q;
  logic [STAGES-1:0]     bin2_q;
  logic [P_W-1:0]        p_d, p2_q;
  logic [ACC_W-1:0]      rd_q, sum_d;
  logic [P_W-1:0]        avg_d;
  logic                  out_fire;

  logic [ACC_W-1:0]      mem_q [FFT_LEN];

  // Frame alignment FSM, counters and stage-1 control
  always_ff @(posedge mclk or posedge i_init) begin
    if (i_init) begin
      state_q    <= StSync;
      bin_q      <= '0;
      frame_q    <= '0;
      v1_q       <= 1'b0;
      first1_q   <= 1'b0;
      last1_q    <= 1'b0;
      bin1_q     <= '0;
      o_err_strb <= 1'b0;
    end else begin
      v1_q       <= 1'b0;
      o_err_strb <= 1'b0;
      if (i_vld) begin
        case (state_q)
          StSync: begin
            if (i_new_fft) begin
              state_q  <= StAccum;
              v1_q     <= 1'b1;
              bin1_q   <= '0;
              first1_q <= 1'b1;
              last1_q  <= (LastFrame == Frame0);
              bin_q    <= STAGES'(1);
              frame_q  <= '0;
            end
          end
          StAccum: begin
            if (i_new_fft && (bin_q != '0)) begin
              // Early frame start: restart the average from this sample
              o_err_strb <= 1'b1;
              v1_q       <= 1'b1;
              bin1_q     <= '0;
              first1_q   <= 1'b1;
              last1_q    <= (LastFrame == Frame0);
              bin_q      <= STAGES'(1);
              frame_q    <= '0;
            end else if (!i_new_fft && (bin_q == '0)) begin
              o_err_strb <= 1'b1;
              state_q    <= StSync;
            end else begin
              v1_q     <= 1'b1;
              bin1_q   <= bin_q;
              first1_q <= (frame_q == Frame0);
              last1_q  <= (frame_q == LastFrame);
              bin_q    <= bin_q + STAGES'(1);
              if (bin_q == LastBin) begin
                frame_q <= (frame_q == LastFrame) ? Frame0 : frame_q + FC_W'(1);
              end
            end
          end
          default: state_q <= StSync;
        endcase
      end
    end
  end

  assign i_ext = P_W'(i_I);
  assign q_ext = P_W'(i_Q);

  always_ff @(posedge mclk) begin
    ii_q <= i_ext * i_ext;
    qq_q <= q_ext * q_ext;
  end

  // Both squares are non-negative and their sum is at most 2^(P_W-1)
  assign p_d = $unsigned(ii_q) + $unsigned(qq_q);

  always_ff @(posedge mclk or posedge i_init) begin
    if (i_init) begin
      v2_q     <= 1'b0;
      first2_q <= 1'b0;
      last2_q  <= 1'b0;
      bin2_q   <= '0;
    end else begin
      v2_q     <= v1_q;
      first2_q <= first1_q;
      last2_q  <= last1_q;
      bin2_q   <= bin1_q;
    end
  end

  always_ff @(posedge mclk) begin
    p2_q <= p_d;
  end

  // Bins recur at least FFT_LEN >= 4 samples apart, so read and write never collide
  always_ff @(posedge mclk) begin
    if (v1_q) begin
      rd_q <= mem_q[bin1_q];
    end
    if (v2_q) begin
      mem_q[bin2_q] <= sum_d;
    end
  end

  always_comb begin
    sum_d = first2_q ? ACC_W'(p2_q) : rd_q + ACC_W'(p2_q);
  end

  assign avg_d    = sum_d[ACC_W-1:AVG_LOG2];
  assign out_fire = v2_q & last2_q;

  always_ff @(posedge mclk or posedge i_init) begin
    if (i_init) begin
      o_vld       <= 1'b0;
      o_new_frame <= 1'b0;
      o_bin       <= '0;
      o_pwr       <= '0;
    end else begin
      o_vld <= out_fire;
      if (out_fire) begin
        o_new_frame <= (bin2_q == '0);
        o_bin       <= bin2_q;
        o_pwr       <= avg_d;
      end
    end
  end

`ifdef FFT_PSD_AVG_PEAK_EN
  logic [STAGES-1:0] pk_bin_q;
  logic [P_W-1:0]    pk_pwr_q;
  logic              pk_done_q;

  always_ff @(posedge mclk or posedge i_init) begin
    if (i_init) begin
      pk_bin_q   <= '0;
      pk_pwr_q   <= '0;
      pk_done_q  <= 1'b0;
      o_peak_vld <= 1'b0;
      o_peak_bin <= '0;
      o_peak_pwr <= '0;
    end else begin
      pk_done_q  <= 1'b0;
      o_peak_vld <= pk_done_q;
      if (pk_done_q) begin
        o_peak_bin <= pk_bin_q;
        o_peak_pwr <= pk_pwr_q;
      end
      if (out_fire) begin
        // Strict compare keeps the lowest bin on ties
        if ((bin2_q == '0) || (avg_d > pk_pwr_q)) begin
          pk_bin_q <= bin2_q;
          pk_pwr_q <= avg_d;
        end
        pk_done_q <= (bin2_q == LastBin);
      end
    end
  end
`else
  assign o_peak_vld = 1'b0;
  assign o_peak_bin = '0;
  assign o_peak_pwr = '0;
`endif

endmodule

// File: tb/tb_fft_psd_avg.sv
// Directed bench for fft_psd_avg: FFT_LEN=8 with AVG_LOG2=2 (dut_a) and AVG_LOG2=4 (dut_b).
// Peak outputs are checked when FFT_PSD_AVG_PEAK_EN is defined, otherwise they must stay 0.

module tb_fft_psd_avg;

  logic mclk = 1'b0;
  logic init;
  always #5 mclk = ~mclk;

  logic               a_vld, a_nf, a_o_vld, a_o_nf, a_o_err, a_pk_vld;
  logic signed [27:0] a_I, a_Q;
  logic [2:0]         a_o_bin, a_pk_bin;
  logic [55:0]        a_o_pwr, a_pk_pwr;

  logic               b_vld, b_nf, b_o_vld, b_o_nf, b_o_err, b_pk_vld;
  logic signed [27:0] b_I, b_Q;
  logic [2:0]         b_o_bin, b_pk_bin;
  logic [55:0]        b_o_pwr, b_pk_pwr;

  fft_psd_avg #(.IN_W(28), .FFT_LEN(8), .AVG_LOG2(2)) dut_a (
    .mclk(mclk), .i_init(init), .i_vld(a_vld), .i_new_fft(a_nf), .i_I(a_I), .i_Q(a_Q),
    .o_vld(a_o_vld), .o_new_frame(a_o_nf), .o_bin(a_o_bin), .o_pwr(a_o_pwr),
    .o_err_strb(a_o_err), .o_peak_vld(a_pk_vld), .o_peak_bin(a_pk_bin), .o_peak_pwr(a_pk_pwr)
  );

  fft_psd_avg #(.IN_W(28), .FFT_LEN(8), .AVG_LOG2(4)) dut_b (
    .mclk(mclk), .i_init(init), .i_vld(b_vld), .i_new_fft(b_nf), .i_I(b_I), .i_Q(b_Q),
    .o_vld(b_o_vld), .o_new_frame(b_o_nf), .o_bin(b_o_bin), .o_pwr(b_o_pwr),
    .o_err_strb(b_o_err), .o_peak_vld(b_pk_vld), .o_peak_bin(b_pk_bin), .o_peak_pwr(b_pk_pwr)
  );

  int n_chk = 0;
  int n_fail = 0;
  int pcyc = 0;
  int err_cnt = 0;

  logic [2:0]  q_bin[$];
  logic [55:0] q_pwr[$];
  logic        q_nf[$];
  int          q_cyc[$];
  logic [2:0]  pk_bin_l[$];
  logic [55:0] pk_pwr_l[$];
  logic [2:0]  qb_bin[$];
  logic [55:0] qb_pwr[$];
  int          sent_q[$];

  always @(posedge mclk) pcyc <= pcyc + 1;

  always @(negedge mclk) begin
    if (a_o_vld) begin
      q_bin.push_back(a_o_bin);
      q_pwr.push_back(a_o_pwr);
      q_nf.push_back(a_o_nf);
      q_cyc.push_back(pcyc);
    end
    if (a_o_err) err_cnt <= err_cnt + 1;
    if (a_pk_vld) begin
      pk_bin_l.push_back(a_pk_bin);
      pk_pwr_l.push_back(a_pk_pwr);
    end
    if (b_o_vld) begin
      qb_bin.push_back(b_o_bin);
      qb_pwr.push_back(b_o_pwr);
    end
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic a_send(input int i_v, input int q_v, input bit nf);
    a_vld = 1'b1;
    a_nf  = nf;
    a_I   = 28'(i_v);
    a_Q   = 28'(q_v);
    tick();
    a_vld = 1'b0;
    a_nf  = 1'b0;
  endtask

  task automatic b_send(input int i_v, input int q_v, input bit nf);
    b_vld = 1'b1;
    b_nf  = nf;
    b_I   = 28'(i_v);
    b_Q   = 28'(q_v);
    tick();
    b_vld = 1'b0;
    b_nf  = 1'b0;
  endtask

  task automatic a_frame(input int i_v, input int q_v);
    for (int b = 0; b < 8; b++) a_send(i_v, q_v, b == 0);
  endtask

  task automatic clear_q();
    q_bin.delete(); q_pwr.delete(); q_nf.delete(); q_cyc.delete();
    pk_bin_l.delete(); pk_pwr_l.delete(); qb_bin.delete(); qb_pwr.delete();
  endtask

  task automatic do_reset();
    init = 1'b1;
    idle(2);
    init = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    n_chk++;
    if (a_o_vld !== 1'b0 || a_o_nf !== 1'b0 || a_o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a_ctrl: got vld=%b nf=%b err=%b required 0", a_o_vld, a_o_nf, a_o_err);
    end
    n_chk++;
    if (a_o_bin !== 3'd0 || a_o_pwr !== 56'd0) begin
      n_fail++;
      $display("FAIL reset_a_data: got bin=%0d pwr=%0d required 0", a_o_bin, a_o_pwr);
    end
    n_chk++;
    if (b_o_vld !== 1'b0 || b_o_pwr !== 56'd0 || b_o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_b: got vld=%b pwr=%0d err=%b required 0", b_o_vld, b_o_pwr, b_o_err);
    end
    n_chk++;
    if (a_pk_vld !== 1'b0 || a_pk_bin !== 3'd0 || a_pk_pwr !== 56'd0) begin
      n_fail++;
      $display("FAIL reset_peak: got vld=%b bin=%0d pwr=%0d required 0", a_pk_vld, a_pk_bin,
               a_pk_pwr);
    end
    init = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    clear_q();
    sent_q.delete();
    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < 8; b++) begin
        if (f == 3) sent_q.push_back(pcyc);
        a_send(3, 4, b == 0);
      end
    end
    idle(6);
    n_chk++;
    if (q_pwr.size() != 8) begin
      n_fail++;
      $display("FAIL basic_count: got %0d outputs required 8", q_pwr.size());
    end
    for (int i = 0; i < q_pwr.size() && i < 8; i++) begin
      n_chk++;
      if (q_bin[i] !== 3'(i) || q_pwr[i] !== 56'd25 || q_nf[i] !== (i == 0)) begin
        n_fail++;
        $display("FAIL basic_out[%0d]: got bin=%0d pwr=%0d nf=%b required bin=%0d pwr=25 nf=%b",
                 i, q_bin[i], q_pwr[i], q_nf[i], i, i == 0);
      end
      n_chk++;
      if (q_cyc[i] != sent_q[i] + 3) begin
        n_fail++;
        $display("FAIL basic_latency[%0d]: got %0d cycles required 3", i, q_cyc[i] - sent_q[i]);
      end
    end
`ifdef FFT_PSD_AVG_PEAK_EN
    n_chk++;
    if (pk_bin_l.size() != 1 || pk_bin_l[0] !== 3'd0 || pk_pwr_l[0] !== 56'd25) begin
      n_fail++;
      $display("FAIL basic_peak: got %0d pulses, first bin=%0d pwr=%0d required 1 pulse bin=0 pwr=25",
               pk_bin_l.size(), pk_bin_l.size() > 0 ? pk_bin_l[0] : 3'd7,
               pk_pwr_l.size() > 0 ? pk_pwr_l[0] : 56'd0);
    end
`else
    n_chk++;
    if (pk_bin_l.size() != 0 || a_pk_pwr !== 56'd0 || a_pk_bin !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_peak_off: got %0d pulses pwr=%0d required none and 0",
               pk_bin_l.size(), a_pk_pwr);
    end
`endif
  endtask

  task automatic test_single_bin();
    clear_q();
    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < 8; b++) a_send((b == 5) ? f + 1 : 0, 0, b == 0);
    end
    idle(6);
    n_chk++;
    if (q_pwr.size() != 8) begin
      n_fail++;
      $display("FAIL single_count: got %0d outputs required 8", q_pwr.size());
    end
    for (int i = 0; i < q_pwr.size() && i < 8; i++) begin
      n_chk++;
      if (q_bin[i] !== 3'(i) || q_pwr[i] !== ((i == 5) ? 56'd7 : 56'd0)) begin
        n_fail++;
        $display("FAIL single_out[%0d]: got bin=%0d pwr=%0d required pwr=%0d", i, q_bin[i],
                 q_pwr[i], (i == 5) ? 7 : 0);
      end
    end
`ifdef FFT_PSD_AVG_PEAK_EN
    n_chk++;
    if (pk_bin_l.size() != 1 || pk_bin_l[0] !== 3'd5 || pk_pwr_l[0] !== 56'd7) begin
      n_fail++;
      $display("FAIL single_peak: got %0d pulses, first bin=%0d pwr=%0d required bin=5 pwr=7",
               pk_bin_l.size(), pk_bin_l.size() > 0 ? pk_bin_l[0] : 3'd0,
               pk_pwr_l.size() > 0 ? pk_pwr_l[0] : 56'd0);
    end
`endif
  endtask

  task automatic test_misalign();
    int e0;
    clear_q();
    e0 = err_cnt;
    a_frame(1, 1);
    for (int b = 0; b < 3; b++) a_send(1, 1, b == 0);
    a_send(2, 0, 1'b1);
    for (int b = 1; b < 8; b++) a_send(2, 0, 1'b0);
    a_frame(2, 0);
    a_frame(2, 0);
    idle(5);
    n_chk++;
    if (q_pwr.size() != 0) begin
      n_fail++;
      $display("FAIL misalign_early: got %0d outputs required 0", q_pwr.size());
    end
    n_chk++;
    if (err_cnt - e0 != 1) begin
      n_fail++;
      $display("FAIL misalign_err: got %0d pulses required 1", err_cnt - e0);
    end
    a_frame(2, 0);
    idle(6);
    n_chk++;
    if (q_pwr.size() != 8) begin
      n_fail++;
      $display("FAIL misalign_count: got %0d outputs required 8", q_pwr.size());
    end
    for (int i = 0; i < q_pwr.size() && i < 8; i++) begin
      n_chk++;
      if (q_bin[i] !== 3'(i) || q_pwr[i] !== 56'd4) begin
        n_fail++;
        $display("FAIL misalign_out[%0d]: got bin=%0d pwr=%0d required pwr=4", i, q_bin[i],
                 q_pwr[i]);
      end
    end
  endtask

  task automatic test_no_sync();
    int e0;
    do_reset();
    clear_q();
    e0 = err_cnt;
    for (int b = 0; b < 8; b++) a_send(3, 4, 1'b0);
    idle(5);
    n_chk++;
    if (q_pwr.size() != 0 || err_cnt != e0) begin
      n_fail++;
      $display("FAIL nosync_discard: got %0d outputs %0d errs required 0 and 0", q_pwr.size(),
               err_cnt - e0);
    end
    a_frame(3, 4);
    a_send(3, 4, 1'b0);
    for (int i = 0; i < 24; i++) a_send(3, 4, 1'b0);
    idle(5);
    n_chk++;
    if (err_cnt - e0 != 1) begin
      n_fail++;
      $display("FAIL nosync_err: got %0d pulses required 1", err_cnt - e0);
    end
    n_chk++;
    if (q_pwr.size() != 0) begin
      n_fail++;
      $display("FAIL nosync_resync: got %0d outputs required 0", q_pwr.size());
    end
  endtask

  task automatic test_gaps();
    do_reset();
    for (int run = 0; run < 2; run++) begin
      clear_q();
      for (int f = 0; f < 4; f++) begin
        for (int b = 0; b < 8; b++) begin
          a_send(b + 1, f, b == 0);
          if (run == 1) idle($urandom_range(0, 5));
        end
      end
      idle(6);
      n_chk++;
      if (q_pwr.size() != 8) begin
        n_fail++;
        $display("FAIL gaps_count run%0d: got %0d outputs required 8", run, q_pwr.size());
      end
      // (4*(b+1)^2 + 0+1+4+9) >> 2
      for (int i = 0; i < q_pwr.size() && i < 8; i++) begin
        n_chk++;
        if (q_bin[i] !== 3'(i) || q_pwr[i] !== 56'((i + 1) * (i + 1) + 3)) begin
          n_fail++;
          $display("FAIL gaps_out run%0d[%0d]: got bin=%0d pwr=%0d required %0d", run, i,
                   q_bin[i], q_pwr[i], (i + 1) * (i + 1) + 3);
        end
      end
    end
  endtask

  task automatic test_init_mid();
    a_frame(5, 0);
    a_frame(5, 0);
    for (int b = 0; b < 3; b++) a_send(5, 0, b == 0);
    #2;
    init = 1'b1;
    #1;
    n_chk++;
    if (a_o_vld !== 1'b0 || a_o_pwr !== 56'd0 || a_o_bin !== 3'd0 || a_o_nf !== 1'b0 ||
        a_o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL init_async: got vld=%b pwr=%0d bin=%0d nf=%b err=%b required 0", a_o_vld,
               a_o_pwr, a_o_bin, a_o_nf, a_o_err);
    end
    idle(2);
    init = 1'b0;
    tick();
    clear_q();
    for (int f = 0; f < 4; f++) a_frame(1, 0);
    idle(6);
    n_chk++;
    if (q_pwr.size() != 8) begin
      n_fail++;
      $display("FAIL init_count: got %0d outputs required 8", q_pwr.size());
    end
    for (int i = 0; i < q_pwr.size() && i < 8; i++) begin
      n_chk++;
      if (q_pwr[i] !== 56'd1) begin
        n_fail++;
        $display("FAIL init_out[%0d]: got pwr=%0d required 1", i, q_pwr[i]);
      end
    end
  endtask

  task automatic test_big();
    logic [55:0] exp_pwr;
    exp_pwr = 56'd1 << 55;
    clear_q();
    for (int f = 0; f < 16; f++) begin
      for (int b = 0; b < 8; b++) b_send(-134217728, -134217728, b == 0);
    end
    idle(6);
    n_chk++;
    if (qb_pwr.size() != 8) begin
      n_fail++;
      $display("FAIL big_count: got %0d outputs required 8", qb_pwr.size());
    end
    for (int i = 0; i < qb_pwr.size() && i < 8; i++) begin
      n_chk++;
      if (qb_bin[i] !== 3'(i) || qb_pwr[i] !== exp_pwr) begin
        n_fail++;
        $display("FAIL big_out[%0d]: got bin=%0d pwr=%0h required %0h", i, qb_bin[i], qb_pwr[i],
                 exp_pwr);
      end
    end
  endtask

  initial begin
    init  = 1'b1;
    a_vld = 1'b0; a_nf = 1'b0; a_I = '0; a_Q = '0;
    b_vld = 1'b0; b_nf = 1'b0; b_I = '0; b_Q = '0;
    idle(2);
    test_reset();
    test_basic();
    test_single_bin();
    test_misalign();
    test_no_sync();
    test_gaps();
    test_init_mid();
    test_big();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
